// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the adder-sharing arbiter: FSM encoding,
// requester count and a one-hot decode helper.
package adder_share_arbiter_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Turn a 2-bit requester index into a 4-bit one-hot grant vector.
  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_pick4.sv
// Round-robin pick: first asserted request scanning from ptr upward, modulo 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  // Walk the four positions starting at ptr; the first hit wins.
  always_comb begin
    logic [1:0] idx;
    winner = ptr;
    any    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4.sv
// Generic 4:1 multiplexer, used once per operand to select the winner's data.
module mux4 #(
  parameter int W = 4
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  // Plain select; sel is always a valid 2-bit index.
  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Four requesters share one W-bit adder. A round-robin pick selects an
// operand pair, the W+1-bit sum is registered with the winner's ID and held
// until the consumer takes it.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [4*W-1:0]   a_bus,
  input  logic [4*W-1:0]   b_bus,
  output logic [3:0]       gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_sum,
  output logic [1:0]       out_id
);

  state_t       state_reg, state_next;
  logic [1:0]   ptr_reg;
  logic [W:0]   sum_reg;
  logic [1:0]   id_reg;

  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];
  logic [W-1:0] a_sel, b_sel;
  logic [1:0]   winner;
  logic         any;
  logic         load;
  logic         capture;

  // Unpack the flat operand buses into per-requester lanes.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign a_arr[gi] = a_bus[gi*W +: W];
    assign b_arr[gi] = b_bus[gi*W +: W];
  end

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .winner (winner),
    .any    (any)
  );

  mux4 #(.W(W)) u_mux_a (
    .d0 (a_arr[0]), .d1 (a_arr[1]), .d2 (a_arr[2]), .d3 (a_arr[3]),
    .sel (winner), .y (a_sel)
  );

  mux4 #(.W(W)) u_mux_b (
    .d0 (b_arr[0]), .d1 (b_arr[1]), .d2 (b_arr[2]), .d3 (b_arr[3]),
    .sel (winner), .y (b_sel)
  );

  // The result register may be (re)filled when empty or being drained this cycle;
  // reset suppresses any capture so no grant is ever reported under reset.
  assign load    = (state_reg == IDLE) || (state_reg == HOLD && out_ready);
  assign capture = load && any && !rst;

  // Next-state and grant decode.
  always_comb begin
    state_next = state_reg;
    gnt        = '0;
    if (capture) begin
      gnt        = onehot4(winner);
      state_next = HOLD;
    end else if (state_reg == HOLD && out_ready) begin
      state_next = IDLE;
    end
  end

  // State, pointer and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      sum_reg   <= '0;
      id_reg    <= 2'd0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        sum_reg <= {1'b0, a_sel} + {1'b0, b_sel};
        id_reg  <= winner;
        ptr_reg <= winner + 2'd1;
      end
    end
  end

  assign out_valid = (state_reg == HOLD);
  assign out_sum   = sum_reg;
  assign out_id    = id_reg;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed table-driven bench for adder_share_arbiter (W=4). Each table row is
// one clock cycle: inputs applied after the rising edge, outputs checked on
// the falling edge (gnt reflects this cycle, result reflects earlier captures).
module tb_adder_share_arbiter;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] a_bus, b_bus;
  logic [3:0]     gnt;
  logic           out_valid;
  logic           out_ready;
  logic [W:0]     out_sum;
  logic [1:0]     out_id;

  always #5 clk = ~clk;

  adder_share_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_id    (out_id)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    logic        rdy;
    logic [3:0]  exp_gnt;
    logic        exp_valid;
    logic [4:0]  exp_sum;
    logic [1:0]  exp_id;
    logic        chk_data;
  } row_t;

  row_t rows[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic [3:0] rq, input logic [15:0] a,
                     input logic [15:0] b, input logic rdy, input logic [3:0] g,
                     input logic v, input logic [4:0] s, input logic [1:0] id,
                     input logic cd);
    row_t x;
    x.rst = r; x.req = rq; x.a = a; x.b = b; x.rdy = rdy;
    x.exp_gnt = g; x.exp_valid = v; x.exp_sum = s; x.exp_id = id; x.chk_data = cd;
    rows.push_back(x);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    int grants;
    bit found;

    //   rst req      a         b         rdy gnt      v  sum    id  chk
    // idle after reset
    for (int i = 0; i < 5; i++)
      add(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 5'h00, 0, 1);
    // single request 2: 9+8
    add(0, 4'b0100, 16'h0900, 16'h0800, 1, 4'b0100, 0, 5'h00, 0, 1);
    add(0, 4'b0000, 16'h0900, 16'h0800, 0, 4'b0000, 1, 5'h11, 2, 1);
    // all request, ptr=3 so 3 wins first, then rotate
    add(0, 4'b1111, 16'h1111, 16'h1111, 1, 4'b1000, 1, 5'h11, 2, 1);
    add(0, 4'b1111, 16'h1111, 16'h1111, 1, 4'b0001, 1, 5'h02, 3, 1);
    add(0, 4'b1111, 16'h1111, 16'h1111, 1, 4'b0010, 1, 5'h02, 0, 1);
    add(0, 4'b1111, 16'h1111, 16'h1111, 1, 4'b0100, 1, 5'h02, 1, 1);
    add(0, 4'b1111, 16'h1111, 16'h1111, 1, 4'b1000, 1, 5'h02, 2, 1);
    add(0, 4'b1111, 16'h1111, 16'h1111, 1, 4'b0001, 1, 5'h02, 3, 1);
    add(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 5'h02, 0, 1);
    add(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 5'h00, 0, 0);
    // backpressure on requester 1
    add(0, 4'b0010, 16'h0030, 16'h0050, 1, 4'b0010, 0, 5'h00, 0, 0);
    add(0, 4'b0010, 16'h0070, 16'h0060, 0, 4'b0000, 1, 5'h08, 1, 1);
    add(0, 4'b0010, 16'h0070, 16'h0060, 0, 4'b0000, 1, 5'h08, 1, 1);
    add(0, 4'b0010, 16'h0070, 16'h0060, 0, 4'b0000, 1, 5'h08, 1, 1);
    add(0, 4'b0010, 16'h0070, 16'h0060, 1, 4'b0010, 1, 5'h08, 1, 1);
    add(0, 4'b0000, 16'h0070, 16'h0060, 0, 4'b0000, 1, 5'h0D, 1, 1);
    // full-scale, then zero operands, then a small sum
    add(0, 4'b0001, 16'h000F, 16'h000F, 1, 4'b0001, 1, 5'h0D, 1, 1);
    add(0, 4'b1000, 16'h0000, 16'h0000, 1, 4'b1000, 1, 5'h1E, 0, 1);
    add(0, 4'b0001, 16'h0001, 16'h0002, 1, 4'b0001, 1, 5'h00, 3, 1);
    // reset while holding; grant forced off under reset
    add(1, 4'b0000, 16'h4002, 16'h4003, 0, 4'b0000, 1, 5'h03, 0, 1);
    add(1, 4'b1001, 16'h4002, 16'h4003, 1, 4'b0000, 0, 5'h00, 0, 1);
    // after reset ptr=0: requester 0 before 3
    add(0, 4'b1001, 16'h4002, 16'h4003, 1, 4'b0001, 0, 5'h00, 0, 1);
    add(0, 4'b1000, 16'h4002, 16'h4003, 1, 4'b1000, 1, 5'h05, 0, 1);
    add(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 5'h08, 3, 1);
    add(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 5'h00, 0, 0);

    rst = 1'b1; req = '0; a_bus = '0; b_bus = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);

    foreach (rows[i]) begin
      #1;
      rst = rows[i].rst; req = rows[i].req; a_bus = rows[i].a;
      b_bus = rows[i].b; out_ready = rows[i].rdy;
      @(negedge clk);
      $display("row %0d: rst=%0b req=%b rdy=%0b -> gnt=%b valid=%0b sum=%0h id=%0d",
               i, rst, req, out_ready, gnt, out_valid, out_sum, out_id);
      check("gnt", i, 32'(gnt), 32'(rows[i].exp_gnt));
      check("out_valid", i, 32'(out_valid), 32'(rows[i].exp_valid));
      if (rows[i].chk_data) begin
        check("out_sum", i, 32'(out_sum), 32'(rows[i].exp_sum));
        check("out_id", i, 32'(out_id), 32'(rows[i].exp_id));
      end
      @(posedge clk);
    end

    // Starvation bound: ptr=0, req=0111 held; requester 2 must be granted on
    // the third grant (0, 1, then 2).
    #1;
    rst = 1'b0; req = 4'b0111; out_ready = 1'b1; a_bus = '0; b_bus = '0;
    grants = 0; found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (gnt != 4'b0000) grants++;
      if (gnt[2]) found = 1'b1;
      $display("starve cycle %0d: gnt=%b grants=%0d", c, gnt, grants);
      @(posedge clk);
      #1;
    end
    check("starve_found", 100, 32'(found), 32'd1);
    check("starve_grants", 100, 32'(grants), 32'd3);
    req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
